// File: rtl/decode_cycle_if.sv
// Bundle carrying the decode stage's IF/ID inputs, writeback port,
// hazard-unit indices and ID/EX outputs.
//   master : upstream side (drives InstrD/PCD/PCPlus4D, FlushE, writeback)
//   slave  : the decode stage itself (drives Rs1D/Rs2D and every *E signal)
interface decode_cycle_if;
  // IF/ID contents
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  // Hazard unit control
  logic        FlushE;
  // Writeback port
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  // Combinational source indices to the hazard unit
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  // ID/EX register outputs
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;

  modport master (
    output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    input  Rs1D, Rs2D,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
    input  ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    output Rs1D, Rs2D,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
    output ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decoders, immediate generator, 32x32
// register file with writeback bypass, and the ID/EX pipeline register.
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous active-low reset; clears register file and ID/EX
//   bus  - decode_cycle_if.slave: IF/ID inputs, FlushE, writeback port,
//          Rs1D/Rs2D to the hazard unit, and all registered *E outputs
module decode_cycle (
  input  logic           clk,
  input  logic           rst,
  decode_cycle_if.slave  bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  // Instruction fields
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  assign instr    = bus.InstrD;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7_5 = instr[30];

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  // Main decoder
  logic       reg_write;
  logic       mem_write;
  logic       jump;
  logic       branch;
  logic       alu_src;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] alu_op;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    imm_src    = IMM_I;
    alu_op     = 2'b00;
    unique case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_SW: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      OP_BEQ: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: ;  // unknown opcode decodes as a bubble
    endcase
  end

  // ALU decoder
  logic [2:0] alu_control;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          // Only R-type (opcode bit 5 set) with funct7[5] is a subtract;
          // addi reuses those bits as immediate.
          3'b000:  alu_control = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Immediate generator, sign-extended from instr[31]
  logic [31:0] imm_ext;

  always_comb begin
    unique case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Register file
  logic [31:0] rf_q [32];
  logic        wb_en;

  assign wb_en = bus.RegWriteW && (bus.RdW != 5'd0);

  // NOTE: the register file must clear on reset, so it is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[bus.RdW] <= bus.ResultW;
    end
  end

  // x0 reads as zero; a same-cycle writeback to the read index is bypassed.
  logic [31:0] rd1;
  logic [31:0] rd2;

  assign rd1 = (rs1 == 5'd0)                ? 32'd0 :
               (wb_en && (bus.RdW == rs1))  ? bus.ResultW : rf_q[rs1];
  assign rd2 = (rs2 == 5'd0)                ? 32'd0 :
               (wb_en && (bus.RdW == rs2))  ? bus.ResultW : rf_q[rs2];

  // ID/EX register
  idex_t idex_d;
  idex_t idex_q;

  always_comb begin
    // NOTE: combinational blocks use blocking '=', clocked blocks use '<='.
    idex_d = '0;
    if (!bus.FlushE) begin
      idex_d.reg_write   = reg_write;
      idex_d.mem_write   = mem_write;
      idex_d.jump        = jump;
      idex_d.branch      = branch;
      idex_d.alu_src     = alu_src;
      idex_d.result_src  = result_src;
      idex_d.alu_control = alu_control;
      idex_d.rd1         = rd1;
      idex_d.rd2         = rd2;
      idex_d.imm_ext     = imm_ext;
      idex_d.pc          = bus.PCD;
      idex_d.pc_plus4    = bus.PCPlus4D;
      idex_d.rs1         = rs1;
      idex_d.rs2         = rs2;
      idex_d.rd          = rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign bus.RegWriteE   = idex_q.reg_write;
  assign bus.MemWriteE   = idex_q.mem_write;
  assign bus.JumpE       = idex_q.jump;
  assign bus.BranchE     = idex_q.branch;
  assign bus.ALUSrcE     = idex_q.alu_src;
  assign bus.ResultSrcE  = idex_q.result_src;
  assign bus.ALUControlE = idex_q.alu_control;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm_ext;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;
  assign bus.RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios followed by
// random instructions, compared against an instruction-level model.
module tb_decode_cycle;

  logic clk;
  logic rst;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        rw, mw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_NONE} kind_t;

  logic [31:0] mregs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx, input exp_t e);
    check({ctx, ".RegWriteE"},   32'(bus.RegWriteE),   32'(e.rw));
    check({ctx, ".MemWriteE"},   32'(bus.MemWriteE),   32'(e.mw));
    check({ctx, ".JumpE"},       32'(bus.JumpE),       32'(e.jump));
    check({ctx, ".BranchE"},     32'(bus.BranchE),     32'(e.branch));
    check({ctx, ".ALUSrcE"},     32'(bus.ALUSrcE),     32'(e.alusrc));
    check({ctx, ".ResultSrcE"},  32'(bus.ResultSrcE),  32'(e.rsrc));
    check({ctx, ".ALUControlE"}, 32'(bus.ALUControlE), 32'(e.aluc));
    check({ctx, ".RD1E"},        bus.RD1E,             e.rd1);
    check({ctx, ".RD2E"},        bus.RD2E,             e.rd2);
    check({ctx, ".ImmExtE"},     bus.ImmExtE,          e.imm);
    check({ctx, ".PCE"},         bus.PCE,              e.pc);
    check({ctx, ".PCPlus4E"},    bus.PCPlus4E,         e.pc4);
    check({ctx, ".Rs1E"},        32'(bus.Rs1E),        32'(e.rs1));
    check({ctx, ".Rs2E"},        32'(bus.Rs2E),        32'(e.rs2));
    check({ctx, ".RdE"},         32'(bus.RdE),         32'(e.rd));
  endtask

  // Architectural register read as seen during the decode cycle.
  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wb_en,
                                             input logic [4:0] wb_rd, input logic [31:0] wb_data);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  // Expected ID/EX contents one edge after presenting instruction i.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] pc4,
                                 input logic flush, input logic wb_en, input logic [4:0] wb_rd,
                                 input logic [31:0] wb_data);
    exp_t e;
    kind_t k;
    logic signed [31:0] s;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    e = '0;
    if (flush) return e;
    case (i[6:0])
      7'h03:   k = K_LW;
      7'h23:   k = K_SW;
      7'h33:   k = K_R;
      7'h13:   k = K_I;
      7'h63:   k = K_BEQ;
      7'h6F:   k = K_JAL;
      default: k = K_NONE;
    endcase
    s     = i;
    imm_i = 32'(s >>> 20);
    imm_s = (imm_i & ~32'h1F) | 32'(i[11:7]);
    imm_b = (i[31] ? 32'hFFFF_F000 : 32'd0) + (32'(i[7]) << 11)
          + (32'(i[30:25]) << 5) + (32'(i[11:8]) << 1);
    imm_j = (i[31] ? 32'hFFF0_0000 : 32'd0) + (32'(i[19:12]) << 12)
          + (32'(i[20]) << 11) + (32'(i[30:21]) << 1);
    // Instructions without their own immediate format carry the I-form value.
    e.imm = imm_i;
    case (k)
      K_LW:  begin e.rw = 1; e.alusrc = 1; e.rsrc = 2'b01; end
      K_SW:  begin e.mw = 1; e.alusrc = 1; e.imm = imm_s; end
      K_R:   e.rw = 1;
      K_I:   begin e.rw = 1; e.alusrc = 1; end
      K_BEQ: begin e.branch = 1; e.imm = imm_b; e.aluc = 3'b001; end
      K_JAL: begin e.rw = 1; e.jump = 1; e.rsrc = 2'b10; e.imm = imm_j; end
      default: ;
    endcase
    if (k == K_R || k == K_I) begin
      case (i[14:12])
        3'b000:  e.aluc = (k == K_R && i[30]) ? 3'b001 : 3'b000;
        3'b010:  e.aluc = 3'b101;
        3'b110:  e.aluc = 3'b011;
        3'b111:  e.aluc = 3'b010;
        default: e.aluc = 3'b000;
      endcase
    end
    e.rd1 = model_read(i[19:15], wb_en, wb_rd, wb_data);
    e.rd2 = model_read(i[24:20], wb_en, wb_rd, wb_data);
    e.pc  = pc;
    e.pc4 = pc4;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    return e;
  endfunction

  // Called at a falling edge: drive one cycle, let the edge pass, check ID/EX.
  task automatic step(input string ctx, input logic [31:0] instr, input logic flush,
                      input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data);
    logic [31:0] pc;
    exp_t e;
    pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.FlushE    = flush;
    bus.RegWriteW = wb_en;
    bus.RdW       = wb_rd;
    bus.ResultW   = wb_data;
    #1;
    check({ctx, ".Rs1D"}, 32'(bus.Rs1D), 32'(instr[19:15]));
    check({ctx, ".Rs2D"}, 32'(bus.Rs2D), 32'(instr[24:20]));
    e = model(instr, pc, pc + 32'd4, flush, wb_en, wb_rd, wb_data);
    if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
    @(posedge clk);
    @(negedge clk);
    check_all(ctx, e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = 7'h03;
      1: op = 7'h23;
      2: op = 7'h33;
      3: op = 7'h13;
      4: op = 7'h63;
      5: op = 7'h6F;
      default: op = 7'($urandom);
    endcase
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom), op};
  endfunction

  initial begin
    exp_t zero;
    zero = '0;
    for (int r = 0; r < 32; r++) mregs[r] = '0;

    // Reset held with random inputs: all outputs stay zero across edges.
    rst           = 1'b0;
    bus.InstrD    = $urandom;
    bus.PCD       = $urandom;
    bus.PCPlus4D  = $urandom;
    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd5;
    bus.ResultW   = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", zero);
    rst = 1'b1;

    // Fresh register file reads zero.
    step("post_reset", 32'h0052_8333, 1'b0, 1'b0, 5'd0, 32'd0);
    check("post_reset.rd1_zero", bus.RD1E, 32'd0);

    // Write x5, then read it back through add x6,x5,x5.
    step("write", 32'h0000_0000, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step("read", 32'h0052_8333, 1'b0, 1'b0, 5'd0, 32'd0);
    check("read.rd1", bus.RD1E, 32'hDEAD_BEEF);
    check("read.rd2", bus.RD2E, 32'hDEAD_BEEF);
    check("read.rw", 32'(bus.RegWriteE), 32'd1);
    check("read.rd", 32'(bus.RdE), 32'd6);

    // Same-cycle writeback bypass.
    step("bypass", 32'h0052_8333, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    check("bypass.rd1", bus.RD1E, 32'h1234_5678);
    check("bypass.rd2", bus.RD2E, 32'h1234_5678);

    // Writes to x0 are dropped.
    step("x0_write", 32'h0000_0333, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step("x0_read", 32'h0000_0333, 1'b0, 1'b0, 5'd0, 32'd0);
    check("x0_read.rd1", bus.RD1E, 32'd0);

    // lw x1,8(x2)
    step("lw", 32'h0081_2083, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lw.imm", bus.ImmExtE, 32'd8);
    check("lw.rsrc", 32'(bus.ResultSrcE), 32'd1);

    // beq x0,x0,-4
    step("beq", 32'hFE00_0EE3, 1'b0, 1'b0, 5'd0, 32'd0);
    check("beq.imm", bus.ImmExtE, 32'hFFFF_FFFC);
    check("beq.aluc", 32'(bus.ALUControlE), 32'd1);

    // Flush with a concurrent writeback: ID/EX clears, x7 is still written.
    step("pre_flush", 32'h0081_2083, 1'b0, 1'b0, 5'd0, 32'd0);
    step("flush", 32'h0081_2083, 1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5);
    check("flush.pce", bus.PCE, 32'd0);
    step("post_flush", 32'h0003_8433, 1'b0, 1'b0, 5'd0, 32'd0);
    check("post_flush.rd1", bus.RD1E, 32'hA5A5_A5A5);

    // Reset mid-operation acts without a clock edge and clears state.
    #2 rst = 1'b0;
    #1 check_all("async_reset", zero);
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    @(negedge clk);
    rst = 1'b1;
    step("after_async", 32'h0052_8333, 1'b0, 1'b0, 5'd0, 32'd0);
    check("after_async.rd1", bus.RD1E, 32'd0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step("rand", rand_instr(), ($urandom_range(0, 9) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
